iccm_arbiter: RTL

Two-requester arbiter for the 4 KB instruction memory (ICCM, DFFRAM-backed, 1-cycle read latency). It shares the single memory port between the core instruction-fetch port (read-only) and a loader port (read/write, used by the boot/program loader). It routes each read response back to the requester that issued it, and generates write acknowledges. Sits between the core/loader and the ICCM wrapper inside the SoC top.

---
 rtl/iccm_arbiter_if.sv | 40 ++++
 rtl/iccm_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/iccm_arbiter_if.sv
// Bus bundle for iccm_arbiter: fetch port, loader port and ICCM memory port.
// slave = arbiter view; master = requester/memory environment view.
interface iccm_arbiter_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;

   logic              l_req;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic [3:0]        l_we;
   logic              l_lock;
   logic              l_gnt;
   logic              l_rvalid;
   logic [DATA_W-1:0] l_rdata;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;

   modport slave (
      input  f_req, f_addr, l_req, l_addr, l_wdata, l_we, l_lock, mem_rdata, mem_rvalid,
      output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
             mem_req, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output f_req, f_addr, l_req, l_addr, l_wdata, l_we, l_lock, mem_rdata, mem_rvalid,
      input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
             mem_req, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/iccm_arbiter.sv
// Fetch/loader arbiter for the single ICCM port with response routing and write acks.
// Define ICCM_ARB_RR_EN for round-robin contention; otherwise the loader has fixed priority.
module iccm_arbiter #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
) (
   input  logic           clock,
   input  logic           reset,
   iccm_arbiter_if.slave  bus
);
   typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} lock_t;

   lock_t             r_lock_st;
   lock_t             w_lock_nxt;
   logic              r_last_owner;
   logic              r_rsp_owner;
   logic              r_rsp_pend;
   logic              r_wack_pend;

   logic              w_lock_hold;
   logic              w_l_wins;
   logic              w_f_gnt;
   logic              w_l_gnt;
   logic              w_l_write;
   logic              w_rd_gnt;
   logic              w_rsp_f;
   logic              w_rsp_l;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

`ifdef ICCM_ARB_RR_EN
   assign w_l_wins = ~r_last_owner;
`else
   logic w_unused_last_owner;
   assign w_unused_last_owner = r_last_owner;
   assign w_l_wins            = 1'b1;
`endif

   // Lock only blocks fetch while l_lock is still high, so fetch regains the port in the cycle it falls.
   assign w_lock_hold = (r_lock_st == LOCKED) & bus.l_lock;
   assign w_l_write   = |bus.l_we;

   assign w_f_gnt  = reset & bus.f_req & ~w_lock_hold & ~(bus.l_req & w_l_wins);
   assign w_l_gnt  = reset & bus.l_req & (w_lock_hold | ~bus.f_req | w_l_wins);
   assign w_rd_gnt = w_f_gnt | (w_l_gnt & ~w_l_write);

   always_comb begin
      w_lock_nxt = r_lock_st;
      case (r_lock_st)
         OPEN:    if (w_l_gnt & bus.l_lock) w_lock_nxt = LOCKED;
         LOCKED:  if (~bus.l_lock)          w_lock_nxt = OPEN;
         default: w_lock_nxt = OPEN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_lock_st    <= OPEN;
         r_last_owner <= 1'b0;
         r_rsp_owner  <= 1'b0;
         r_rsp_pend   <= 1'b0;
         r_wack_pend  <= 1'b0;
      end else begin
         r_lock_st   <= w_lock_nxt;
         r_rsp_pend  <= w_rd_gnt;
         r_wack_pend <= w_l_gnt & w_l_write;
         if (w_rd_gnt) r_rsp_owner <= w_l_gnt;
         if (w_f_gnt)      r_last_owner <= 1'b0;
         else if (w_l_gnt) r_last_owner <= 1'b1;
      end
   end

   always_comb begin
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      bus.mem_we  = '0;
      if (w_f_gnt) begin
         w_mem_addr = bus.f_addr;
      end else if (w_l_gnt) begin
         w_mem_addr  = bus.l_addr;
         w_mem_wdata = bus.l_wdata;
         bus.mem_we  = bus.l_we;
      end
   end

   assign bus.mem_req   = w_f_gnt | w_l_gnt;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.f_gnt     = w_f_gnt;
   assign bus.l_gnt     = w_l_gnt;

   assign w_rsp_f      = bus.mem_rvalid & r_rsp_pend & ~r_rsp_owner;
   assign w_rsp_l      = bus.mem_rvalid & r_rsp_pend &  r_rsp_owner;
   assign bus.f_rvalid = w_rsp_f;
   assign bus.f_rdata  = w_rsp_f ? bus.mem_rdata : '0;
   assign bus.l_rvalid = w_rsp_l | r_wack_pend;
   assign bus.l_rdata  = w_rsp_l ? bus.mem_rdata : '0;
endmodule
